// File: rtl/energy_monitor_pkg.sv
// energy_monitor_pkg
// Shared definitions for the energy monitor sequencer slice:
//   - em_state_e : sequencer FSM states (IDLE, CFG, SPIN, STREAM, WAIT_E, DONE)
//   - CREDIT_W / CREDIT_MAX : read-credit counter width and its ceiling, which
//     equals the skid buffer depth
//   - rows_f / addr_bit_f : derive the number of weight rows per evaluation
//     and the row address width from DATASPIN and PARALLELISM
package energy_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CFG    = 3'd1,
    SPIN   = 3'd2,
    STREAM = 3'd3,
    WAIT_E = 3'd4,
    DONE   = 3'd5
  } em_state_e;

  localparam int CREDIT_W = 2;
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = 2'd2;

  function automatic int rows_f(input int dataspin, input int parallelism);
    return dataspin / parallelism;
  endfunction

  function automatic int addr_bit_f(input int dataspin, input int parallelism);
    return $clog2(dataspin / parallelism);
  endfunction

endpackage

// File: rtl/energy_monitor_sequencer_skid.sv
// em_skid_buffer
// Two-entry valid/ready FIFO holding weight rows between the weight memory
// and the energy monitor.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset (empties buffer)
//   push_i, push_data_i  write strobe and row; ignored while full
//   full_o               both entries occupied
//   pop_valid_o          at least one entry occupied
//   pop_data_o           oldest entry (FIFO head)
//   pop_i                consume the head; ignored while empty
module em_skid_buffer #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  output logic         full_o,
  output logic         pop_valid_o,
  output logic [W-1:0] pop_data_o,
  input  logic         pop_i
);

  logic [W-1:0] entry_q [2];
  logic [W-1:0] entry_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full_o      = (count_q == 2'd2);
  assign pop_valid_o = (count_q != 2'd0);
  assign pop_data_o  = entry_q[rd_ptr_q];

  // Ring of two entries; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    entry_d  = entry_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    do_push  = push_i && !full_o;
    do_pop   = pop_i && pop_valid_o;
    if (do_push) begin
      entry_d[wr_ptr_q] = push_data_i;
      wr_ptr_d          = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q  <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      entry_q  <= entry_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/energy_monitor_sequencer.sv
// energy_monitor_sequencer
// Runs one energy evaluation: accepts a job (spin vector + start row), hands
// the start counter and spins to the energy monitor, streams ROWS weight rows
// from a fixed-latency memory through a 2-entry skid buffer under credit flow
// control, then returns the monitor's energy to the requester.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   en_i                          low freezes FSM, counters and buffer
//   job_*                         job request handshake (ready only in IDLE)
//   cfg_*                         config handshake to the monitor
//   spin_*                        spin vector handshake to the monitor
//   mem_req_o/mem_addr_o          weight memory read request
//   mem_rvalid_i/mem_rdata_i      read return, MEM_LAT cycles after request
//   weight_*                      weight row handshake to the monitor
//   energy_*                      energy result from the monitor
//   result_*                      captured energy to the requester
//   busy_o                        sequencer not idle
// Optional feature, macro EM_SEQ_MIN_TRACK_EN:
//   min_clear_i, min_energy_o, min_spin_o track the lowest energy seen and the
//   spin vector that produced it.
module energy_monitor_sequencer
  import energy_monitor_pkg::*;
#(
  parameter int DATASPIN         = 256,
  parameter int PARALLELISM      = 4,
  parameter int ENERGY_TOTAL_BIT = 32,
  parameter int ROW_W            = 4*256*4+4*4+4*4,
  parameter int MEM_LAT          = 1,
  parameter int SPINIDX_BIT      = $clog2(DATASPIN),
  parameter int ADDR_BIT         = addr_bit_f(DATASPIN, PARALLELISM)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               en_i,
  input  logic                               job_valid_i,
  output logic                               job_ready_o,
  input  logic [DATASPIN-1:0]                job_spin_i,
  input  logic [ADDR_BIT-1:0]                job_start_row_i,
  output logic                               cfg_valid_o,
  output logic [SPINIDX_BIT-1:0]             cfg_counter_o,
  input  logic                               cfg_ready_i,
  output logic                               spin_valid_o,
  output logic [DATASPIN-1:0]                spin_o,
  input  logic                               spin_ready_i,
  output logic                               mem_req_o,
  output logic [ADDR_BIT-1:0]                mem_addr_o,
  input  logic                               mem_rvalid_i,
  input  logic [ROW_W-1:0]                   mem_rdata_i,
  output logic                               weight_valid_o,
  output logic [ROW_W-1:0]                   weight_row_o,
  input  logic                               weight_ready_i,
  input  logic                               energy_valid_i,
  input  logic signed [ENERGY_TOTAL_BIT-1:0] energy_i,
  output logic                               energy_ready_o,
  output logic                               result_valid_o,
  output logic signed [ENERGY_TOTAL_BIT-1:0] result_energy_o,
  input  logic                               result_ready_i,
  output logic                               busy_o
`ifdef EM_SEQ_MIN_TRACK_EN
  ,
  input  logic                               min_clear_i,
  output logic signed [ENERGY_TOTAL_BIT-1:0] min_energy_o,
  output logic [DATASPIN-1:0]                min_spin_o
`endif
);

  localparam int ROWS  = rows_f(DATASPIN, PARALLELISM);
  localparam int CNT_W = ADDR_BIT + 1;
  localparam logic [CNT_W-1:0]    ROWS_C    = CNT_W'(ROWS);
  localparam logic [ADDR_BIT-1:0] LAST_ADDR = ADDR_BIT'(ROWS - 1);

  em_state_e                          state_q, state_d;
  logic [DATASPIN-1:0]                spin_q, spin_d;
  logic [ADDR_BIT-1:0]                start_row_q, start_row_d;
  logic [ADDR_BIT-1:0]                addr_q, addr_d;
  logic [CNT_W-1:0]                   issued_q, issued_d;
  logic [CNT_W-1:0]                   done_q, done_d;
  logic [CREDIT_W-1:0]                credit_q, credit_d;
  logic signed [ENERGY_TOTAL_BIT-1:0] result_q, result_d;
  logic [MEM_LAT-1:0]                 slot_q, slot_d;

  logic rvalid_ok;
  logic weight_hs;
  logic buf_full;

  assign job_ready_o     = (state_q == IDLE);
  assign busy_o          = (state_q != IDLE);
  assign cfg_valid_o     = (state_q == CFG);
  assign spin_valid_o    = (state_q == SPIN);
  assign energy_ready_o  = (state_q == WAIT_E);
  assign result_valid_o  = (state_q == DONE);
  assign spin_o          = spin_q;
  assign mem_addr_o      = addr_q;
  assign result_energy_o = result_q;
  assign cfg_counter_o   = SPINIDX_BIT'(32'(start_row_q) * PARALLELISM);

  // A read may only be issued while a buffer slot is guaranteed for its data.
  assign mem_req_o = en_i && (state_q == STREAM) && (credit_q != '0) && (issued_q != ROWS_C);
  assign weight_hs = en_i && weight_valid_o && weight_ready_i;

  // slot_q marks the cycles in which a return is expected; anything else on
  // mem_rvalid_i is stray and must not enter the buffer. This pipeline follows
  // the memory rather than en_i so data already in flight when the block is
  // frozen is still captured instead of lost.
  assign slot_d    = (slot_q << 1) | MEM_LAT'(mem_req_o);
  assign rvalid_ok = mem_rvalid_i && slot_q[MEM_LAT-1];

  em_skid_buffer #(
    .W (ROW_W)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (rvalid_ok),
    .push_data_i (mem_rdata_i),
    .full_o      (buf_full),
    .pop_valid_o (weight_valid_o),
    .pop_data_o  (weight_row_o),
    .pop_i       (weight_hs)
  );

  // Main sequencing FSM. Credits count free buffer slots not yet promised to
  // an outstanding read; with a ceiling of two, returns can never overflow.
  always_comb begin
    state_d     = state_q;
    spin_d      = spin_q;
    start_row_d = start_row_q;
    addr_d      = addr_q;
    issued_d    = issued_q;
    done_d      = done_q;
    credit_d    = credit_q;
    result_d    = result_q;
    if (en_i) begin
      case (state_q)
        IDLE: begin
          if (job_valid_i) begin
            spin_d      = job_spin_i;
            start_row_d = job_start_row_i;
            addr_d      = job_start_row_i;
            issued_d    = '0;
            done_d      = '0;
            credit_d    = CREDIT_MAX;
            state_d     = CFG;
          end
        end
        CFG: begin
          if (cfg_ready_i) state_d = SPIN;
        end
        SPIN: begin
          if (spin_ready_i) state_d = STREAM;
        end
        STREAM: begin
          if (mem_req_o) begin
            addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_BIT'(1);
            issued_d = issued_q + CNT_W'(1);
          end
          if (mem_req_o && !weight_hs) begin
            credit_d = credit_q - CREDIT_W'(1);
          end else if (!mem_req_o && weight_hs) begin
            credit_d = credit_q + CREDIT_W'(1);
          end
          if (weight_hs) begin
            done_d = done_q + CNT_W'(1);
            if (done_q + CNT_W'(1) == ROWS_C) state_d = WAIT_E;
          end
        end
        WAIT_E: begin
          if (energy_valid_i) begin
            result_d = energy_i;
            state_d  = DONE;
          end
        end
        DONE: begin
          if (result_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      spin_q      <= '0;
      start_row_q <= '0;
      addr_q      <= '0;
      issued_q    <= '0;
      done_q      <= '0;
      credit_q    <= CREDIT_MAX;
      result_q    <= '0;
      slot_q      <= '0;
    end else begin
      state_q     <= state_d;
      spin_q      <= spin_d;
      start_row_q <= start_row_d;
      addr_q      <= addr_d;
      issued_q    <= issued_d;
      done_q      <= done_d;
      credit_q    <= credit_d;
      result_q    <= result_d;
      slot_q      <= slot_d;
    end
  end

`ifdef EM_SEQ_MIN_TRACK_EN
  localparam logic signed [ENERGY_TOTAL_BIT-1:0] E_MAX = {1'b0, {(ENERGY_TOTAL_BIT-1){1'b1}}};

  logic                               min_valid_q, min_valid_d;
  logic signed [ENERGY_TOTAL_BIT-1:0] min_energy_q, min_energy_d;
  logic [DATASPIN-1:0]                min_spin_q, min_spin_d;
  logic                               capture;

  assign capture      = en_i && (state_q == WAIT_E) && energy_valid_i;
  assign min_energy_o = min_energy_q;
  assign min_spin_o   = min_spin_q;

  // Running minimum over captured energies; a clear only drops the valid flag,
  // so the next capture is taken unconditionally.
  always_comb begin
    min_valid_d  = min_valid_q;
    min_energy_d = min_energy_q;
    min_spin_d   = min_spin_q;
    if (min_clear_i) begin
      min_valid_d = 1'b0;
    end else if (capture && (!min_valid_q || (energy_i < min_energy_q))) begin
      min_valid_d  = 1'b1;
      min_energy_d = energy_i;
      min_spin_d   = spin_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_valid_q  <= 1'b0;
      min_energy_q <= E_MAX;
      min_spin_q   <= '0;
    end else begin
      min_valid_q  <= min_valid_d;
      min_energy_q <= min_energy_d;
      min_spin_q   <= min_spin_d;
    end
  end
`endif

`ifndef SYNTHESIS
  stray_rvalid_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> slot_q[MEM_LAT-1]);
  no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_ok |-> !buf_full);
`endif

endmodule

// File: tb/tb_energy_monitor_sequencer.sv
// tb_energy_monitor_sequencer
// Directed and randomized jobs against energy_monitor_sequencer with a small
// memory model, a configurable monitor ready pattern and a behavioural
// reference for addresses, row order, result and running minimum.
// Optional feature, macro EM_SEQ_MIN_TRACK_EN, is exercised when defined.
module tb_energy_monitor_sequencer;

  localparam int DATASPIN    = 16;
  localparam int PARALLELISM = 4;
  localparam int EW          = 32;
  localparam int ROW_W       = 32;
  localparam int MEM_LAT     = 1;
  localparam int ROWS        = DATASPIN / PARALLELISM;
  localparam int SPINIDX_BIT = 4;
  localparam int ADDR_BIT    = 2;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   en_i;
  logic                   job_valid_i;
  logic                   job_ready_o;
  logic [DATASPIN-1:0]    job_spin_i;
  logic [ADDR_BIT-1:0]    job_start_row_i;
  logic                   cfg_valid_o;
  logic [SPINIDX_BIT-1:0] cfg_counter_o;
  logic                   cfg_ready_i;
  logic                   spin_valid_o;
  logic [DATASPIN-1:0]    spin_o;
  logic                   spin_ready_i;
  logic                   mem_req_o;
  logic [ADDR_BIT-1:0]    mem_addr_o;
  logic                   mem_rvalid_i;
  logic [ROW_W-1:0]       mem_rdata_i;
  logic                   weight_valid_o;
  logic [ROW_W-1:0]       weight_row_o;
  logic                   weight_ready_i;
  logic                   energy_valid_i;
  logic signed [EW-1:0]   energy_i;
  logic                   energy_ready_o;
  logic                   result_valid_o;
  logic signed [EW-1:0]   result_energy_o;
  logic                   result_ready_i;
  logic                   busy_o;
`ifdef EM_SEQ_MIN_TRACK_EN
  logic                   min_clear_i;
  logic signed [EW-1:0]   min_energy_o;
  logic [DATASPIN-1:0]    min_spin_o;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int readyMode = 0;
  bit allOnes  = 1'b1;

  int               reqAddrs[$];
  logic [ROW_W-1:0] gotRows[$];
  int               maxOut;
  int               acceptCnt;
  int               firstReqCyc;
  int               acceptCyc;

  bit                  mValid;
  int                  mE;
  logic [DATASPIN-1:0] mS;

  energy_monitor_sequencer #(
    .DATASPIN         (DATASPIN),
    .PARALLELISM      (PARALLELISM),
    .ENERGY_TOTAL_BIT (EW),
    .ROW_W            (ROW_W),
    .MEM_LAT          (MEM_LAT)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .en_i            (en_i),
    .job_valid_i     (job_valid_i),
    .job_ready_o     (job_ready_o),
    .job_spin_i      (job_spin_i),
    .job_start_row_i (job_start_row_i),
    .cfg_valid_o     (cfg_valid_o),
    .cfg_counter_o   (cfg_counter_o),
    .cfg_ready_i     (cfg_ready_i),
    .spin_valid_o    (spin_valid_o),
    .spin_o          (spin_o),
    .spin_ready_i    (spin_ready_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .weight_valid_o  (weight_valid_o),
    .weight_row_o    (weight_row_o),
    .weight_ready_i  (weight_ready_i),
    .energy_valid_i  (energy_valid_i),
    .energy_i        (energy_i),
    .energy_ready_o  (energy_ready_o),
    .result_valid_o  (result_valid_o),
    .result_energy_o (result_energy_o),
    .result_ready_i  (result_ready_i),
    .busy_o          (busy_o)
`ifdef EM_SEQ_MIN_TRACK_EN
    ,
    .min_clear_i     (min_clear_i),
    .min_energy_o    (min_energy_o),
    .min_spin_o      (min_spin_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Row content as a function of its address, so order and address can both
  // be checked from the data alone.
  function automatic logic [ROW_W-1:0] rowData(input int addr);
    if (allOnes) return '1;
    return {8'hC3, 8'(addr), 16'(addr * 13 + 7)};
  endfunction

  // Fixed-latency weight memory; its pipeline is cleared with the DUT reset.
  logic             pendV;
  logic [ROW_W-1:0] pendD;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pendV <= 1'b0;
      pendD <= '0;
    end else begin
      pendV <= mem_req_o;
      pendD <= rowData(int'(mem_addr_o));
    end
  end
  assign mem_rvalid_i = pendV;
  assign mem_rdata_i  = pendD;

  // Monitor-side ready pattern: always ready, weight ready one cycle in three,
  // or random stalls on every handshake.
  always @(posedge clk_i) begin
    #1;
    case (readyMode)
      0:       weight_ready_i = 1'b1;
      1:       weight_ready_i = (cyc % 3 == 0);
      default: weight_ready_i = 1'($urandom_range(0, 1));
    endcase
    cfg_ready_i  = (readyMode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    spin_ready_i = (readyMode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard capture, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (job_valid_i && job_ready_o && en_i) acceptCnt++;
      if (mem_req_o) begin
        reqAddrs.push_back(int'(mem_addr_o));
        if (firstReqCyc < 0) firstReqCyc = cyc;
      end
      if (weight_valid_o && weight_ready_i && en_i) gotRows.push_back(weight_row_o);
      if (reqAddrs.size() - gotRows.size() > maxOut) maxOut = reqAddrs.size() - gotRows.size();
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string p);
    checkOutput({p, "_job_ready"}, job_ready_o, 1);
    checkOutput({p, "_busy"}, busy_o, 0);
    checkOutput({p, "_cfg_valid"}, cfg_valid_o, 0);
    checkOutput({p, "_spin_valid"}, spin_valid_o, 0);
    checkOutput({p, "_mem_req"}, mem_req_o, 0);
    checkOutput({p, "_weight_valid"}, weight_valid_o, 0);
    checkOutput({p, "_energy_ready"}, energy_ready_o, 0);
    checkOutput({p, "_result_valid"}, result_valid_o, 0);
    checkOutput({p, "_result_energy"}, result_energy_o, 0);
    checkOutput({p, "_spin_o"}, spin_o, 0);
    checkOutput({p, "_cfg_counter"}, cfg_counter_o, 0);
    checkOutput({p, "_mem_addr"}, mem_addr_o, 0);
`ifdef EM_SEQ_MIN_TRACK_EN
    checkOutput({p, "_min_energy"}, min_energy_o, 32'h7FFF_FFFF);
    checkOutput({p, "_min_spin"}, min_spin_o, 0);
`endif
  endtask

  task automatic clearScoreboard();
    reqAddrs.delete();
    gotRows.delete();
    maxOut      = 0;
    acceptCnt   = 0;
    firstReqCyc = -1;
  endtask

  // One complete job from request to result acceptance.
  task automatic applyStimulus(input int start, input logic [DATASPIN-1:0] spin, input int energy,
                               input bit holdValid, input bit freeze);
    int expA;
    clearScoreboard();
    job_spin_i      = spin;
    job_start_row_i = ADDR_BIT'(start);
    job_valid_i     = 1'b1;
    step();
    acceptCyc = cyc;
    if (!holdValid) job_valid_i = 1'b0;
    checkOutput("accept_busy", busy_o, 1);
    checkOutput("cfg_counter", cfg_counter_o, start * PARALLELISM);
    checkOutput("spin_latched", spin_o, spin);
    if (freeze) begin
      en_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
        step();
        checkOutput("freeze_no_req", mem_req_o, 0);
        checkOutput("freeze_cfg_hold", cfg_valid_o, 1);
      end
      en_i = 1'b1;
    end
    for (int i = 0; i < 400 && !energy_ready_o; i++) step();
    checkOutput("reach_wait_e", energy_ready_o, 1);
    checkOutput("job_ready_low_busy", job_ready_o, 0);
    checkOutput("req_count", reqAddrs.size(), ROWS);
    checkOutput("row_count", gotRows.size(), ROWS);
    for (int i = 0; i < ROWS; i++) begin
      expA = (start + i) % ROWS;
      if (i < reqAddrs.size()) checkOutput("req_addr", reqAddrs[i], expA);
      if (i < gotRows.size()) checkOutput("row_data", gotRows[i], rowData(expA));
    end
    checkOutput("max_outstanding_le2", maxOut <= 2, 1);
    if (readyMode != 2 && !freeze) checkOutput("first_req_latency", firstReqCyc - acceptCyc, 2);

    energy_i       = energy;
    energy_valid_i = 1'b1;
    step();
    energy_valid_i = 1'b0;
    if (holdValid) job_valid_i = 1'b0;
    checkOutput("result_valid", result_valid_o, 1);
    checkOutput("result_energy", result_energy_o, energy);
    checkOutput("energy_ready_drop", energy_ready_o, 0);
    if (!mValid || energy < mE) begin
      mValid = 1'b1;
      mE     = energy;
      mS     = spin;
    end
`ifdef EM_SEQ_MIN_TRACK_EN
    checkOutput("min_energy", min_energy_o, mE);
    checkOutput("min_spin", min_spin_o, mS);
`endif
    step();
    step();
    checkOutput("result_hold", result_valid_o, 1);
    result_ready_i = 1'b1;
    step();
    result_ready_i = 1'b0;
    checkOutput("result_valid_drop", result_valid_o, 0);
    checkOutput("back_to_idle", job_ready_o, 1);
    checkOutput("idle_not_busy", busy_o, 0);
    checkOutput("single_accept", acceptCnt, 1);
  endtask

  task automatic resetModel();
    mValid = 1'b0;
    mE     = 32'h7FFF_FFFF;
    mS     = '0;
  endtask

  initial begin
    rst_ni          = 1'b0;
    en_i            = 1'b1;
    job_valid_i     = 1'b0;
    job_spin_i      = '0;
    job_start_row_i = '0;
    cfg_ready_i     = 1'b1;
    spin_ready_i    = 1'b1;
    weight_ready_i  = 1'b1;
    energy_valid_i  = 1'b0;
    energy_i        = '0;
    result_ready_i  = 1'b0;
`ifdef EM_SEQ_MIN_TRACK_EN
    min_clear_i     = 1'b0;
`endif
    resetModel();
    clearScoreboard();

    repeat (3) step();
    checkReset("rst");
    @(negedge clk_i) rst_ni = 1'b1;
    step();

    $display("[TB] start row 0, all-ones rows, energy -37");
    applyStimulus(0, 16'hBEEF, -37, 1'b0, 1'b0);

    $display("[TB] start row 3, address-tagged rows");
    allOnes = 1'b0;
    applyStimulus(3, 16'($urandom), int'($urandom), 1'b0, 1'b0);

    $display("[TB] weight ready one cycle in three");
    readyMode = 1;
    applyStimulus(1, 16'($urandom), int'($urandom), 1'b0, 1'b0);
    applyStimulus(2, 16'($urandom), int'($urandom), 1'b0, 1'b0);

    $display("[TB] job_valid held high through the job");
    readyMode = 0;
    applyStimulus($urandom_range(0, ROWS - 1), 16'($urandom), int'($urandom), 1'b1, 1'b0);

    $display("[TB] en_i low freezes a job in CFG");
    applyStimulus(2, 16'($urandom), int'($urandom), 1'b0, 1'b1);

    $display("[TB] en_i low in IDLE blocks acceptance");
    en_i        = 1'b0;
    job_valid_i = 1'b1;
    repeat (3) step();
    checkOutput("en_low_no_accept", busy_o, 0);
    job_valid_i = 1'b0;
    en_i        = 1'b1;

    $display("[TB] reset pulse mid-stream");
    clearScoreboard();
    job_spin_i      = 16'h1234;
    job_start_row_i = 2'd1;
    job_valid_i     = 1'b1;
    step();
    job_valid_i = 1'b0;
    for (int i = 0; i < 50 && reqAddrs.size() == 0; i++) step();
    checkOutput("midrst_saw_req", reqAddrs.size() > 0, 1);
    #2 rst_ni = 1'b0;
    #1;
    resetModel();
    checkReset("midrst");
    @(negedge clk_i) rst_ni = 1'b1;
    step();
    applyStimulus(1, 16'($urandom), int'($urandom), 1'b0, 1'b0);

    $display("[TB] random stalls, random jobs");
    readyMode = 2;
    for (int j = 0; j < 6; j++) begin
      applyStimulus($urandom_range(0, ROWS - 1), 16'($urandom), int'($urandom), 1'b0, 1'b0);
    end

`ifdef EM_SEQ_MIN_TRACK_EN
    $display("[TB] minimum tracking");
    readyMode   = 0;
    min_clear_i = 1'b1;
    step();
    min_clear_i = 1'b0;
    mValid      = 1'b0;
    applyStimulus(0, 16'h0005, 5, 1'b0, 1'b0);
    applyStimulus(1, 16'hA5A5, -3, 1'b0, 1'b0);
    applyStimulus(2, 16'h0002, 2, 1'b0, 1'b0);
    checkOutput("min_after_three", min_energy_o, -3);
    checkOutput("min_spin_after_three", min_spin_o, 16'hA5A5);
    min_clear_i = 1'b1;
    step();
    min_clear_i = 1'b0;
    mValid      = 1'b0;
    applyStimulus(3, 16'h0707, 7, 1'b0, 1'b0);
    checkOutput("min_after_clear", min_energy_o, 7);
    checkOutput("min_spin_after_clear", min_spin_o, 16'h0707);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
